// File: rtl/bank_pkg.sv
// Shared types for the parametrised scratch bank.
// Op encodings, controller states and the lane-count helper.
package bank_pkg;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_INV  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/bank_sweep_ctrl.sv
// Valid-array clear sequencer for bank_param.
// Walks every entry once after reset or flush, then idles.
module bank_sweep_ctrl
    import bank_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_e            state;
    state_e            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SWEEP;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        busy     = 1'b0;
        clr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nx = SWEEP;
                    ptr_nx   = '0;
                end
            end
            SWEEP: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                ptr_nx = ptr + ADDR_W'(1);
                if (ptr == LAST) state_nx = IDLE;
            end
            default: state_nx = SWEEP;
        endcase
    end

    assign clr_addr = ptr;

endmodule

// File: rtl/bank_param.sv
// Single-port scratch bank with per-entry valid bits.
// Valid bits live in plain RAM; a sweep clears them after reset/flush.
module bank_param
    import bank_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    localparam int LANES = lanes_of(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [LANES-1:0]  req_wmask,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              valid_q [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    op_e               op;
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              inv_acc;
    logic              wr_any;
    logic              rd_hit;

    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic [DATA_W-1:0] rsp_data_q;

    bank_sweep_ctrl #(.ADDR_W(ADDR_W)) u_sweep (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign op        = op_e'(req_op);
    assign req_ready = !busy && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && (op == OP_RD);
    assign wr_acc    = accept && (op == OP_WR);
    assign inv_acc   = accept && (op == OP_INV);
    assign wr_any    = wr_acc && (|req_wmask);
    assign rd_hit    = valid_q[req_addr];

    // Sweep and requests never overlap, so one write port suffices.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[clr_addr] <= 1'b0;
        end else if (wr_any) begin
            valid_q[req_addr] <= 1'b1;
        end else if (inv_acc) begin
            valid_q[req_addr] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_acc && req_wmask[i]) begin
                mem[req_addr][8*i +: 8] <= req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rd_acc;
            rsp_hit_q   <= rd_acc && rd_hit;
            rsp_data_q  <= (rd_acc && rd_hit) ? mem[req_addr] : '0;
        end
    end

    // A response due in a reset cycle belongs to a discarded request.
    assign rsp_valid = rsp_valid_q && !reset;
    assign rsp_hit   = rsp_hit_q && !reset;
    assign rsp_data  = reset ? '0 : rsp_data_q;

endmodule

// File: tb/tb_bank_param.sv
// Directed bench for bank_param: an 8-bit/256-entry instance
// and a 16-bit/16-entry instance, hand-computed expectations.
module tb_bank_param;
    import bank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       a_reset = 1'b1;
    logic       a_valid = 1'b0;
    logic       a_flush = 1'b0;
    logic [1:0] a_op    = 2'b00;
    logic [7:0] a_addr  = 8'h00;
    logic [7:0] a_data  = 8'h00;
    logic [0:0] a_wmask = 1'b0;
    logic       a_ready;
    logic       a_rsp_valid;
    logic       a_rsp_hit;
    logic       a_busy;
    logic [7:0] a_rsp_data;

    logic        b_reset = 1'b1;
    logic        b_valid = 1'b0;
    logic        b_flush = 1'b0;
    logic [1:0]  b_op    = 2'b00;
    logic [3:0]  b_addr  = 4'h0;
    logic [15:0] b_data  = 16'h0000;
    logic [1:0]  b_wmask = 2'b00;
    logic        b_ready;
    logic        b_rsp_valid;
    logic        b_rsp_hit;
    logic        b_busy;
    logic [15:0] b_rsp_data;

    bank_param #(.DATA_W(8), .ADDR_W(8)) u_a (
        .clk       (clk),
        .reset     (a_reset),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_op    (a_op),
        .req_addr  (a_addr),
        .req_data  (a_data),
        .req_wmask (a_wmask),
        .flush     (a_flush),
        .rsp_valid (a_rsp_valid),
        .rsp_data  (a_rsp_data),
        .rsp_hit   (a_rsp_hit),
        .busy      (a_busy)
    );

    bank_param #(.DATA_W(16), .ADDR_W(4)) u_b (
        .clk       (clk),
        .reset     (b_reset),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_op    (b_op),
        .req_addr  (b_addr),
        .req_data  (b_data),
        .req_wmask (b_wmask),
        .flush     (b_flush),
        .rsp_valid (b_rsp_valid),
        .rsp_data  (b_rsp_data),
        .rsp_hit   (b_rsp_hit),
        .busy      (b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic a_req(input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] data, input logic m);
        a_valid = 1'b1;
        a_op    = op;
        a_addr  = addr;
        a_data  = data;
        a_wmask = m;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic a_rd(input string tag, input logic [7:0] addr,
                        input logic hit, input logic [7:0] data);
        a_req(OP_RD, addr, 8'h00, 1'b0);
        @(negedge clk);
        chk({tag, "_v"}, 32'(a_rsp_valid), 32'd1);
        chk({tag, "_h"}, 32'(a_rsp_hit), 32'(hit));
        chk({tag, "_d"}, 32'(a_rsp_data), 32'(data));
        @(posedge clk);
        #1;
    endtask

    task automatic a_sweep(input string tag, input int exp);
        int n = 0;
        int bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!a_busy) break;
            n++;
            if (a_ready) bad++;
        end
        chk({tag, "_len"}, 32'(n), 32'(exp));
        chk({tag, "_rdy"}, 32'(bad), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic b_req(input logic [1:0] op, input logic [3:0] addr,
                         input logic [15:0] data, input logic [1:0] m);
        b_valid = 1'b1;
        b_op    = op;
        b_addr  = addr;
        b_data  = data;
        b_wmask = m;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    task automatic b_rd(input string tag, input logic [3:0] addr,
                        input logic hit, input logic [15:0] data);
        b_req(OP_RD, addr, 16'h0000, 2'b00);
        @(negedge clk);
        chk({tag, "_v"}, 32'(b_rsp_valid), 32'd1);
        chk({tag, "_h"}, 32'(b_rsp_hit), 32'(hit));
        chk({tag, "_d"}, 32'(b_rsp_data), 32'(data));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rv", 32'(a_rsp_valid), 32'd0);
        chk("rst_hit", 32'(a_rsp_hit), 32'd0);
        chk("rst_data", 32'(a_rsp_data), 32'h00);
        chk("rst_rdy", 32'(a_ready), 32'd0);
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        a_sweep("boot", 256);

        a_rd("rd10", 8'h10, 1'b0, 8'h00);

        // write then read on the very next cycle
        a_req(OP_WR, 8'h03, 8'hA5, 1'b1);
        a_rd("rd03", 8'h03, 1'b1, 8'hA5);

        a_req(OP_WR, 8'h09, 8'h77, 1'b1);
        a_req(OP_INV, 8'h09, 8'h00, 1'b0);
        a_rd("inv09", 8'h09, 1'b0, 8'h00);
        a_req(OP_WR, 8'h09, 8'h55, 1'b1);
        a_rd("rew09", 8'h09, 1'b1, 8'h55);

        // read, then flush on the following cycle
        a_req(OP_WR, 8'h20, 8'h3C, 1'b1);
        a_valid = 1'b1;
        a_op    = OP_RD;
        a_addr  = 8'h03;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_flush = 1'b1;
        @(negedge clk);
        chk("fl_rv", 32'(a_rsp_valid), 32'd1);
        chk("fl_hit", 32'(a_rsp_hit), 32'd1);
        chk("fl_data", 32'(a_rsp_data), 32'hA5);
        chk("fl_rdy", 32'(a_ready), 32'd0);
        @(posedge clk);
        #1;
        a_flush = 1'b0;
        a_sweep("flush", 256);
        a_rd("pf03", 8'h03, 1'b0, 8'h00);
        a_rd("pf20", 8'h20, 1'b0, 8'h00);

        // read accepted just before reset yields no response
        a_req(OP_WR, 8'h20, 8'h3C, 1'b1);
        a_valid = 1'b1;
        a_op    = OP_RD;
        a_addr  = 8'h20;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_reset = 1'b1;
        @(negedge clk);
        chk("rr_rv", 32'(a_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        @(negedge clk);
        chk("rr_rv2", 32'(a_rsp_valid), 32'd0);
        chk("rr_busy", 32'(a_busy), 32'd1);

        // reset at sweep pointer 100 restarts the full sweep
        repeat (100) @(posedge clk);
        #1;
        a_reset = 1'b1;
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        a_sweep("mid", 256);
        a_rd("mid20", 8'h20, 1'b0, 8'h00);

        // 16-bit instance
        b_reset = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!b_busy) break;
            n++;
        end
        chk("b_boot_len", 32'(n), 32'd16);
        @(posedge clk);
        #1;
        b_req(OP_WR, 4'h5, 16'h1234, 2'b11);
        b_req(OP_WR, 4'h5, 16'hABCD, 2'b10);
        b_rd("b_rd5", 4'h5, 1'b1, 16'hAB34);
        b_req(OP_WR, 4'h6, 16'hFFFF, 2'b00);
        b_rd("b_rd6", 4'h6, 1'b0, 16'h0000);
        b_req(OP_RSVD, 4'h5, 16'h0000, 2'b11);
        @(negedge clk);
        chk("b_rsvd_rv", 32'(b_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        b_rd("b_rsvd5", 4'h5, 1'b1, 16'hAB34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
